// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system ID check sequencer.
package sysid_checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_WAIT_ID,
      ST_RD_TS,
      ST_WAIT_TS,
      ST_DONE
   } state_t;

   localparam logic        SYSID_ADDR_ID = 1'b0;
   localparam logic        SYSID_ADDR_TS = 1'b1;
   localparam logic [31:0] SYSID_DEF_ID  = 32'd0;
   localparam logic [31:0] SYSID_DEF_TS  = 32'd1355118694;
   localparam int          CTR_W         = 16;

endpackage

// File: rtl/sysid_checker_wait_ctr.sv
// Loadable down-counter shared by the read-latency wait and the waitrequest timeout.
module sysid_checker_wait_ctr
   import sysid_checker_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [CTR_W-1:0]  load_val,
   input  logic              dec,
   output logic              tc
);

   logic [CTR_W-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read sequencer: fetches ID and timestamp words and flags mismatches or stalls.
module sysid_checker
   import sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = SYSID_DEF_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEF_TS,
   parameter int          READ_LATENCY       = 0,
   parameter int          TIMEOUT_CYCLES     = 255
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   // Counter holds "remaining - 1" so terminal count lands on the last allowed cycle.
   localparam logic [CTR_W-1:0] TO_LOAD  = CTR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CTR_W-1:0] LAT_LOAD = CTR_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   state_t           state, state_nxt;
   logic             auto_pending;
   logic             ctr_load, ctr_dec, ctr_tc;
   logic [CTR_W-1:0] ctr_val;
   logic             cap_id, cap_ts, abort;

   sysid_checker_wait_ctr u_wait_ctr (
      .clock    (clock),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (ctr_val),
      .dec      (ctr_dec),
      .tc       (ctr_tc)
   );

   always_comb begin
      state_nxt = state;
      ctr_load  = 1'b0;
      ctr_val   = TO_LOAD;
      ctr_dec   = 1'b0;
      cap_id    = 1'b0;
      cap_ts    = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start || auto_pending) begin
               state_nxt = ST_RD_ID;
               ctr_load  = 1'b1;
            end
         end
         ST_RD_ID, ST_RD_TS: begin
            if (!avm_waitrequest) begin
               ctr_load = 1'b1;
               if (READ_LATENCY == 0) begin
                  cap_id    = (state == ST_RD_ID);
                  cap_ts    = (state == ST_RD_TS);
                  state_nxt = (state == ST_RD_ID) ? ST_RD_TS : ST_DONE;
               end else begin
                  ctr_val   = LAT_LOAD;
                  state_nxt = (state == ST_RD_ID) ? ST_WAIT_ID : ST_WAIT_TS;
               end
            end else if (ctr_tc) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         ST_WAIT_ID, ST_WAIT_TS: begin
            if (ctr_tc) begin
               ctr_load  = 1'b1;
               cap_id    = (state == ST_WAIT_ID);
               cap_ts    = (state == ST_WAIT_TS);
               state_nxt = (state == ST_WAIT_ID) ? ST_RD_TS : ST_DONE;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus strobes and status are registered from the next state so they track the FSM exactly.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         auto_pending <= 1'b1;
         avm_read     <= 1'b0;
         avm_address  <= SYSID_ADDR_ID;
         busy         <= 1'b0;
         done         <= 1'b0;
         id_ok        <= 1'b0;
         ts_ok        <= 1'b0;
         timeout      <= 1'b0;
         captured_id  <= '0;
         captured_ts  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE) begin
            auto_pending <= 1'b0;
         end
         avm_read    <= (state_nxt == ST_RD_ID) || (state_nxt == ST_RD_TS);
         avm_address <= ((state_nxt == ST_RD_TS) || (state_nxt == ST_WAIT_TS)) ?
                        SYSID_ADDR_TS : SYSID_ADDR_ID;
         busy        <= (state_nxt != ST_IDLE);
         done        <= (state_nxt == ST_DONE);
         if (cap_id) begin
            captured_id <= avm_readdata;
         end
         if (cap_ts) begin
            captured_ts <= avm_readdata;
            id_ok       <= (captured_id == EXPECTED_ID);
            ts_ok       <= (avm_readdata == EXPECTED_TIMESTAMP);
            timeout     <= 1'b0;
         end
         if (abort) begin
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench: two sequencers (latency 0 / latency 2 with short timeout) against modelled ID slaves.
module tb_sysid_checker;

   localparam logic [31:0] TS_GOOD = 32'd1355118694;

   typedef struct {
      logic [31:0] cid;
      logic [31:0] cts;
      logic        idok;
      logic        tsok;
      logic        tmo;
      int          cyc;
      int          stalls;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst[2]   = '{1'b1, 1'b1};
   logic        start[2] = '{1'b0, 1'b0};
   logic        addr[2], rd[2], wr[2], busy[2], done[2], idok[2], tsok[2], tmo[2];
   logic [31:0] rdata[2], cid[2], cts[2];

   logic [31:0] id_word[2]  = '{32'd0, 32'd0};
   logic [31:0] ts_word[2]  = '{TS_GOOD, TS_GOOD};
   int          stall_id[2] = '{0, 0};
   bit          stuck[2]    = '{1'b0, 1'b0};

   int   scnt[2]        = '{0, 0};
   int   seen_stalls[2] = '{0, 0};
   bit   sa_v[2]        = '{1'b0, 1'b0};
   logic sa[2]          = '{1'b0, 1'b0};
   bit   glitch[2]      = '{1'b0, 1'b0};
   bit   pend[2]        = '{1'b0, 1'b0};
   logic pend_addr[2]   = '{1'b0, 1'b0};
   int   age[2]         = '{0, 0};

   exp_t q0[$];
   exp_t q1[$];
   exp_t mon_e;
   int   stall_base[2] = '{0, 0};
   bit   idle_nxt[2]   = '{1'b0, 1'b0};
   bit   finish_req    = 1'b0;
   int   total = 0;
   int   bad   = 0;

   sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255)) u_dut_l0 (
      .clock(clk), .reset(rst[0]), .start(start[0]),
      .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .id_ok(idok[0]), .ts_ok(tsok[0]), .timeout(tmo[0]),
      .captured_id(cid[0]), .captured_ts(cts[0])
   );

   sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8)) u_dut_l2 (
      .clock(clk), .reset(rst[1]), .start(start[1]),
      .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .id_ok(idok[1]), .ts_ok(tsok[1]), .timeout(tmo[1]),
      .captured_id(cid[1]), .captured_ts(cts[1])
   );

   function automatic int lat(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   // Slave model: programmable stalls, data valid only in the exact latency slot.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         wr[k]    = rd[k] && (stuck[k] || (scnt[k] < (addr[k] ? 0 : stall_id[k])));
         rdata[k] = 32'hDEAD_BEEF;
         if (lat(k) == 0) begin
            if (rd[k] && !wr[k]) rdata[k] = addr[k] ? ts_word[k] : id_word[k];
         end else if (pend[k] && (age[k] == lat(k))) begin
            rdata[k] = pend_addr[k] ? ts_word[k] : id_word[k];
         end
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rd[k] && wr[k]) begin
            scnt[k]        <= scnt[k] + 1;
            seen_stalls[k] <= seen_stalls[k] + 1;
         end else begin
            scnt[k] <= 0;
         end
         if (rd[k]) begin
            if (sa_v[k] && (addr[k] != sa[k])) glitch[k] <= 1'b1;
            sa_v[k] <= wr[k];
            sa[k]   <= addr[k];
         end else begin
            sa_v[k] <= 1'b0;
         end
         if (rd[k] && !wr[k] && (lat(k) > 0)) begin
            pend[k]      <= 1'b1;
            pend_addr[k] <= addr[k];
            age[k]       <= 1;
         end else if (pend[k]) begin
            if (age[k] >= lat(k)) pend[k] <= 1'b0;
            else age[k] <= age[k] + 1;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input int c, input logic [31:0] ci, input logic [31:0] ct,
                       input logic io, input logic to_ok, input logic tm, input int st);
      exp_t e;
      e.cid = ci; e.cts = ct; e.idok = io; e.tsok = to_ok; e.tmo = tm; e.cyc = c; e.stalls = st;
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Monitor: reset values while reset is high, scoreboard pop on every done pulse.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            check($sformatf("rst_ctl%0d", k),
                  {25'd0, rd[k], addr[k], busy[k], done[k], idok[k], tsok[k], tmo[k]}, 32'd0);
            check($sformatf("rst_cid%0d", k), cid[k], 32'd0);
            check($sformatf("rst_cts%0d", k), cts[k], 32'd0);
            idle_nxt[k] = 1'b0;
         end else begin
            if (idle_nxt[k]) begin
               check($sformatf("idle_after_done%0d", k), {30'd0, busy[k], done[k]}, 32'd0);
               idle_nxt[k] = 1'b0;
            end
            if (done[k]) begin
               if (((k == 0) ? q0.size() : q1.size()) == 0) begin
                  check($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
               end else begin
                  mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("done_cycle%0d", k), 32'(cyc), 32'(mon_e.cyc));
                  check($sformatf("id_ok%0d", k), {31'd0, idok[k]}, {31'd0, mon_e.idok});
                  check($sformatf("ts_ok%0d", k), {31'd0, tsok[k]}, {31'd0, mon_e.tsok});
                  check($sformatf("timeout%0d", k), {31'd0, tmo[k]}, {31'd0, mon_e.tmo});
                  check($sformatf("captured_id%0d", k), cid[k], mon_e.cid);
                  check($sformatf("captured_ts%0d", k), cts[k], mon_e.cts);
                  check($sformatf("busy_read_at_done%0d", k), {30'd0, busy[k], rd[k]}, 32'd2);
                  check($sformatf("stall_cycles%0d", k), 32'(seen_stalls[k] - stall_base[k]),
                        32'(mon_e.stalls));
                  check($sformatf("addr_stable%0d", k), {31'd0, glitch[k]}, 32'd0);
                  stall_base[k] = seen_stalls[k];
                  idle_nxt[k]   = 1'b1;
               end
            end
         end
      end
      if (finish_req) begin
         check("pending_expect0", 32'(q0.size()), 32'd0);
         check("pending_expect1", 32'(q1.size()), 32'd0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c;
      repeat (3) @(negedge clk);
      // automatic check after reset release on both instances
      c = cyc;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      push(0, c + 3, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 0);
      push(1, c + 7, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 0);
      repeat (12) @(negedge clk);

      // timestamp off by one
      ts_word[0] = TS_GOOD + 32'd1;
      c = cyc;
      start[0] = 1'b1;
      push(0, c + 3, 32'd0, TS_GOOD + 32'd1, 1'b1, 1'b0, 1'b0, 0);
      @(negedge clk) start[0] = 1'b0;
      repeat (8) @(negedge clk);

      // latency 2 with three stall cycles on the ID read
      stall_id[1] = 3;
      c = cyc;
      start[1] = 1'b1;
      push(1, c + 10, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 3);
      @(negedge clk) start[1] = 1'b0;
      repeat (14) @(negedge clk);
      stall_id[1] = 0;

      // waitrequest stuck: abort after 8 stalls, captured words unchanged
      id_word[1] = 32'hA5A5_0001;
      ts_word[1] = 32'h5A5A_0002;
      stuck[1]   = 1'b1;
      c = cyc;
      start[1] = 1'b1;
      push(1, c + 9, 32'd0, TS_GOOD, 1'b0, 1'b0, 1'b1, 8);
      @(negedge clk) start[1] = 1'b0;
      repeat (12) @(negedge clk);
      stuck[1]   = 1'b0;
      id_word[1] = 32'd0;
      ts_word[1] = TS_GOOD;

      // start repeated while busy and during the DONE cycle
      ts_word[0] = TS_GOOD;
      c = cyc;
      start[0] = 1'b1;
      push(0, c + 3, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 0);
      @(negedge clk) start[0] = 1'b0;
      @(negedge clk) start[0] = 1'b1;
      repeat (2) @(negedge clk);
      start[0] = 1'b0;
      repeat (8) @(negedge clk);

      // reset mid WAIT_TS; partial ID capture must be discarded
      id_word[1] = 32'h0BAD_0001;
      start[1] = 1'b1;
      @(negedge clk) start[1] = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst[1]     = 1'b1;
      id_word[1] = 32'd0;
      repeat (2) @(negedge clk);
      c = cyc;
      rst[1] = 1'b0;
      push(1, c + 7, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 0);
      repeat (12) @(negedge clk);

      finish_req = 1'b1;
   end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time and on-demand sequencer for the system ID peripheral: acts as a single Avalon-MM read master on the ID slave's control port. It fetches the system ID word (address 0) and the build timestamp word (address 1), then compares both against build-time expectations. Results are presented as sticky status flags and captured words for the CPU status register and the board LED logic. It sits between the ID slave and the status/interrupt fabric, and is the only master that sequences that slave.

## Interface
- EXPECTED_ID, 32'd0, system ID value required at address 0
- EXPECTED_TIMESTAMP, 32'd1355118694, timestamp value required at address 1
- READ_LATENCY, 0, cycles from accepted read to valid readdata (legal 0..3)
- TIMEOUT_CYCLES, 255, max consecutive waitrequest cycles per read (legal 1..65535)

- clock  in  1  single system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request for a new check
- avm_address  out  1  word address to ID slave (0 = ID, 1 = timestamp)
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at check completion
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout  out  1  last check aborted on waitrequest timeout
- captured_id  out  32  ID word from last check
- captured_ts  out  32  timestamp word from last check

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- Reset sets an internal auto_pending bit: first edge after reset release behaves as start (one automatic check per reset).
- IDLE: start or auto_pending -> RD_ID; clears auto_pending. start in any other state is ignored (not queued).
- RD_ID: avm_read=1, avm_address=0, held stable until waitrequest=0. On acceptance: READ_LATENCY=0 -> capture readdata into captured_id that edge, go RD_TS; else go WAIT_ID.
- WAIT_ID: latency counter counts READ_LATENCY-1 down to 0; capture readdata on the cycle it reaches 0, go RD_TS.
- RD_TS/WAIT_TS: identical with address 1, captured_ts, exit to DONE.
- DONE: done=1 for exactly one cycle; id_ok/ts_ok/timeout updated this edge; -> IDLE.
- Timeout: 16-bit counter counts cycles in RD_ID/RD_TS with waitrequest=1; reset on acceptance or state entry. Reaching TIMEOUT_CYCLES: drop avm_read, timeout=1, id_ok=ts_ok=0, captured words unchanged for the unread word, -> DONE.
- Flags are sticky: hold until next DONE. busy=1 in every state except IDLE.
- Comparisons are full 32-bit equality; no masking.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, captured_id=0, captured_ts=0, state IDLE.
- All outputs registered; avm_read/avm_address driven from state register.
- start sampled at edge N -> busy and avm_read high from cycle N+1.
- Zero-wait slave: start-to-done = 2*(1+READ_LATENCY)+1 cycles (3 cycles at latency 0); each waitrequest cycle adds one.
- Reset asserted mid-check: avm_read drops asynchronously, partial captures discarded, auto check reruns after release.
- start coincident with DONE cycle: ignored.

## Structure
- Package sysid_checker_pkg: state enumeration, SYSID_ADDR_ID=0, SYSID_ADDR_TS=1, default expectation constants.
- One sub-module natural: sysid_checker_wait_ctr, a loadable down-counter shared for latency and timeout counting (terminal-count output).

## Test plan
- Reset release, zero-wait slave returning 0 / 1355118694, latency 0 -> done at cycle 3, id_ok=1, ts_ok=1, timeout=0, busy low after done.
- Slave returns timestamp 1355118695 -> ts_ok=0, id_ok=1, captured_ts=1355118695.
- READ_LATENCY=2, waitrequest high 3 cycles on ID read -> done 10 cycles after start, address stable during stalls, correct captures.
- waitrequest stuck high, TIMEOUT_CYCLES=8 -> avm_read drops after 8 stall cycles, timeout=1, id_ok=ts_ok=0, done pulses once.
- start pulsed while busy and on DONE cycle -> exactly one check, one done pulse.
- reset asserted during WAIT_TS -> outputs at reset values immediately, new automatic check completes after release.
